// File: rtl/hud_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : hud_ram_if
// Description : Bus bundle for the HUD character RAM. It carries the external
//               write port, the display read port, the score/lives request
//               pulses and the engine status outputs.
//               master : the client (writer, display reader, game logic)
//               slave  : hud_ram
// Revision    : 1.0 - initial release
// ============================================================================
interface hud_ram_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        data_In;        // external write data (ASCII)
    logic [ADDR_W-1:0] write_address;  // external write address
    logic              we;             // external write enable
    logic [ADDR_W-1:0] read_address;   // display read address
    logic [7:0]        data_Out;       // registered read data
    logic              add_req;        // pulse: add add_pts to the score
    logic [7:0]        add_pts;        // two BCD digits {tens, units}
    logic              lives_dec;      // pulse: lose one life
    logic              busy;           // engine not idle
    logic              done;           // write-back completed
    logic              game_over;      // lives == 0

    modport master (
        output data_In, write_address, we, read_address,
        output add_req, add_pts, lives_dec,
        input  data_Out, busy, done, game_over
    );

    modport slave (
        input  data_In, write_address, we, read_address,
        input  add_req, add_pts, lives_dec,
        output data_Out, busy, done, game_over
    );
endinterface
`default_nettype wire

// File: rtl/hud_ram.sv
`default_nettype none
// ============================================================================
// Module      : hud_ram
// Description : DEPTH x 8 HUD character RAM with a small score/lives engine.
//               The engine keeps a BCD score and a lives count and writes
//               their ASCII digits back into the RAM on request.
// Ports       : Clk     - clock, all logic on the rising edge
//               Reset_n - synchronous active-low reset
//               bus     - hud_ram_if.slave (write/read ports, requests,
//                         busy/done/game_over status)
// Revision    : 1.0 - initial release
// ============================================================================
module hud_ram #(
    parameter int DEPTH        = 160,
    parameter int ADDR_W       = 8,
    parameter int SCORE_BASE   = 7,
    parameter int SCORE_DIGITS = 4,
    parameter int LIVES_ADDR   = 32,
    parameter int LIVES_INIT   = 2
) (
    input  wire logic Clk,
    input  wire logic Reset_n,
    hud_ram_if.slave  bus
);
    localparam int         c_SW          = 4 * SCORE_DIGITS;
    localparam logic [47:0] c_SCORE_TXT  = "Score:";
    localparam logic [47:0] c_LIVES_TXT  = "Lives:";

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_ADD      = 2'd1;
    localparam logic [1:0] c_S_SCORE_WB = 2'd2;
    localparam logic [1:0] c_S_LIVES_WB = 2'd3;

    // Power-up image of one cell
    function automatic logic [7:0] f_init(input int idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx >= 0 && idx < 6)
            v = c_SCORE_TXT[8*(5-idx) +: 8];
        if (idx >= 25 && idx < 31)
            v = c_LIVES_TXT[8*(30-idx) +: 8];
        if (idx >= SCORE_BASE && idx < SCORE_BASE + SCORE_DIGITS)
            v = 8'h30;
        if (idx == LIVES_ADDR)
            v = 8'h30 + 8'(LIVES_INIT);
        return v;
    endfunction

    logic [1:0]        r_state;
    logic [2:0]        r_digit;
    logic [c_SW-1:0]   r_score;
    logic [3:0]        r_lives;
    logic              r_pend_add;
    logic [7:0]        r_pts;
    logic              r_pend_dec;
    logic              r_force_lives;
    logic              r_done;
    logic [7:0]        r_data_out;

    logic [7:0]        w_cells [DEPTH];
    logic [7:0]        w_rd_data;
    logic              w_eng_we;
    logic [ADDR_W-1:0] w_eng_addr;
    logic [7:0]        w_eng_data;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_wr_data;
    logic [3:0]        w_wb_digit;
    logic [3:0]        w_lives_nxt;
    logic [c_SW-1:0]   w_sum;
    logic              w_carry;
    logic [3:0]        w_add;
    logic [4:0]        w_dsum;

    // Storage: one register per cell so each can carry its power-up value.
    // Addresses >= DEPTH match no cell, so such writes fall away.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        logic [7:0] r_cell = f_init(gi);
        always_ff @(posedge Clk) begin
            if (w_wr_en && w_wr_addr == ADDR_W'(gi))
                r_cell <= w_wr_data;
        end
        assign w_cells[gi] = r_cell;
    end

    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < DEPTH; i++)
            if (bus.read_address == ADDR_W'(i))
                w_rd_data = w_cells[i];
    end

    // Digit being written this cycle, most significant first
    always_comb begin
        w_wb_digit = 4'h0;
        for (int i = 0; i < SCORE_DIGITS; i++)
            if (r_digit == 3'(SCORE_DIGITS - 1 - i))
                w_wb_digit = r_score[4*i +: 4];
    end

    // A forced (post-reset) write-back restores lives without decrementing
    always_comb begin
        w_lives_nxt = r_lives;
        if (!r_force_lives && r_lives != 4'd0)
            w_lives_nxt = r_lives - 4'd1;
    end

    // BCD ripple add of the latched two-digit value, saturating at all 9s
    always_comb begin
        w_sum   = r_score;
        w_carry = 1'b0;
        w_add   = 4'h0;
        w_dsum  = 5'd0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            w_add  = (i == 0) ? r_pts[3:0] : ((i == 1) ? r_pts[7:4] : 4'h0);
            w_dsum = {1'b0, r_score[4*i +: 4]} + {1'b0, w_add} + {4'h0, w_carry};
            if (w_dsum > 5'd9) begin
                w_dsum  = w_dsum - 5'd10;
                w_carry = 1'b1;
            end else begin
                w_carry = 1'b0;
            end
            w_sum[4*i +: 4] = w_dsum[3:0];
        end
        // A single-digit score cannot absorb a non-zero tens digit
        if (SCORE_DIGITS == 1 && r_pts[7:4] != 4'h0)
            w_carry = 1'b1;
        if (w_carry)
            w_sum = {SCORE_DIGITS{4'h9}};
    end

    // Write arbitration: the engine owns the port whenever it writes
    always_comb begin
        w_eng_we   = Reset_n && (r_state == c_S_SCORE_WB || r_state == c_S_LIVES_WB);
        w_eng_addr = ADDR_W'(SCORE_BASE) + ADDR_W'(r_digit);
        w_eng_data = {4'h3, w_wb_digit};
        if (r_state == c_S_LIVES_WB) begin
            w_eng_addr = ADDR_W'(LIVES_ADDR);
            w_eng_data = {4'h3, w_lives_nxt};
        end
        w_wr_en   = w_eng_we | bus.we;
        w_wr_addr = w_eng_we ? w_eng_addr : bus.write_address;
        w_wr_data = w_eng_we ? w_eng_data : bus.data_In;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= c_S_SCORE_WB;
            r_digit       <= 3'd0;
            r_score       <= '0;
            r_lives       <= 4'(LIVES_INIT);
            r_pend_add    <= 1'b0;
            r_pts         <= 8'h00;
            r_pend_dec    <= 1'b0;
            r_force_lives <= 1'b1;
            r_done        <= 1'b0;
            r_data_out    <= 8'h00;
        end else begin
            r_data_out <= w_rd_data;
            r_done     <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    // Same-cycle requests are honoured so ADD follows at once
                    if (r_pend_add || bus.add_req)
                        r_state <= c_S_ADD;
                    else if (r_pend_dec || bus.lives_dec)
                        r_state <= c_S_LIVES_WB;
                end
                c_S_ADD: begin
                    r_score    <= w_sum;
                    r_pend_add <= 1'b0;
                    r_digit    <= 3'd0;
                    r_state    <= c_S_SCORE_WB;
                end
                c_S_SCORE_WB: begin
                    if (r_digit == 3'(SCORE_DIGITS - 1)) begin
                        if (r_force_lives || r_pend_dec || bus.lives_dec) begin
                            r_state <= c_S_LIVES_WB;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_digit <= r_digit + 3'd1;
                    end
                end
                default: begin
                    r_lives       <= w_lives_nxt;
                    r_force_lives <= 1'b0;
                    if (!r_force_lives)
                        r_pend_dec <= 1'b0;
                    r_state <= c_S_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
            // New requests win over the clears above
            if (bus.add_req) begin
                r_pend_add <= 1'b1;
                r_pts      <= bus.add_pts;
            end
            if (bus.lives_dec)
                r_pend_dec <= 1'b1;
        end
    end

    assign bus.data_Out  = r_data_out;
    assign bus.busy      = (r_state != c_S_IDLE);
    assign bus.done      = r_done;
    assign bus.game_over = (r_lives == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_hud_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_hud_ram
// Description : Self-checking bench for hud_ram. A decimal score/lives model
//               and a byte-array image of the RAM provide expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hud_ram;
    localparam int DEPTH  = 160;
    localparam int ADDR_W = 8;
    localparam int SB     = 7;
    localparam int SD     = 4;
    localparam int LA     = 32;
    localparam int LI     = 2;

    logic Clk = 1'b0;
    logic Reset_n;

    hud_ram_if #(.ADDR_W(ADDR_W)) bus ();

    hud_ram #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SCORE_BASE(SB),
        .SCORE_DIGITS(SD), .LIVES_ADDR(LA), .LIVES_INIT(LI)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always @(negedge Clk) if (bus.done === 1'b1) done_cnt++;

    // Reference model
    logic [7:0] m_mem [256];
    int         m_score;
    int         m_lives;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_power_up();
        string s;
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        s = "Score:";
        for (int k = 0; k < 6; k++) m_mem[k] = s[k];
        s = "Lives:";
        for (int k = 0; k < 6; k++) m_mem[25+k] = s[k];
        for (int k = 0; k < SD; k++) m_mem[SB+k] = "0";
        m_mem[LA] = 8'h30 + 8'(LI);
    endtask

    task automatic model_cells();
        int p;
        for (int k = 0; k < SD; k++) begin
            p = 1;
            for (int j = 0; j < SD-1-k; j++) p = p * 10;
            m_mem[SB+k] = 8'h30 + 8'((m_score / p) % 10);
        end
        m_mem[LA] = 8'h30 + 8'(m_lives);
    endtask

    task automatic model_add(input logic [7:0] pts);
        int maxv;
        maxv = 1;
        for (int j = 0; j < SD; j++) maxv = maxv * 10;
        m_score = m_score + 10 * int'(pts[7:4]) + int'(pts[3:0]);
        if (m_score > maxv - 1) m_score = maxv - 1;
    endtask

    task automatic model_dec();
        if (m_lives > 0) m_lives = m_lives - 1;
    endtask

    function automatic logic [7:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    task automatic rd_chk(input int a);
        bus.read_address = ADDR_W'(a);
        tick();
        check_eq($sformatf("rd%0d", a), bus.data_Out, m_mem[a]);
    endtask

    task automatic sweep();
        for (int a = 0; a < 256; a++) rd_chk(a);
    endtask

    task automatic status_chk(input string tag);
        for (int k = 0; k < SD; k++) rd_chk(SB + k);
        rd_chk(LA);
        check_eq({tag, "_gover"}, bus.game_over, (m_lives == 0));
    endtask

    // Waits for two consecutive idle samples, bounded
    task automatic wait_quiet(input string tag);
        int idle_run;
        idle_run = 0;
        for (int c = 0; c < 200 && idle_run < 2; c++) begin
            if (bus.busy === 1'b0) idle_run++;
            else idle_run = 0;
            if (idle_run < 2) tick();
        end
        check_eq({tag, "_quiet"}, idle_run, 2);
    endtask

    task automatic ext_wr(input int a, input logic [7:0] d);
        bus.we = 1'b1;
        bus.write_address = ADDR_W'(a);
        bus.data_In = d;
        tick();
        bus.we = 1'b0;
        if (a < DEPTH) m_mem[a] = d;
    endtask

    task automatic run_op(input bit do_add, input logic [7:0] pts, input bit do_dec, input string tag);
        int lat, exp_lat, d0;
        d0 = done_cnt;
        exp_lat = do_add ? (do_dec ? SD + 3 : SD + 2) : 2;
        bus.add_req = do_add;
        bus.add_pts = pts;
        bus.lives_dec = do_dec;
        tick();
        bus.add_req = 1'b0;
        bus.lives_dec = 1'b0;
        bus.add_pts = 8'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        wait_quiet(tag);
        check_eq({tag, "_done"}, done_cnt - d0, 1);
        if (do_add) model_add(pts);
        if (do_dec) model_dec();
        model_cells();
        status_chk(tag);
    endtask

    task automatic do_reset(input string tag);
        int d0;
        bus.read_address = '0;
        Reset_n = 1'b0;
        tick();
        check_eq({tag, "_busy"}, bus.busy, 1);
        check_eq({tag, "_done0"}, bus.done, 0);
        check_eq({tag, "_dout0"}, bus.data_Out, 0);
        check_eq({tag, "_gover"}, bus.game_over, (LI == 0));
        tick();
        Reset_n = 1'b1;
        d0 = done_cnt;
        wait_quiet(tag);
        check_eq({tag, "_done"}, done_cnt - d0, 1);
        m_score = 0;
        m_lives = LI;
        model_cells();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, a;
        logic [7:0] d;
        Reset_n = 1'b0;
        bus.data_In = 8'h00;
        bus.write_address = '0;
        bus.we = 1'b0;
        bus.read_address = '0;
        bus.add_req = 1'b0;
        bus.add_pts = 8'h00;
        bus.lives_dec = 1'b0;
        model_power_up();
        m_score = 0;
        m_lives = LI;

        // Reset and power-up image
        do_reset("rst");
        sweep();

        // 0x45 then 0x67 -> 0112
        d0 = done_cnt;
        run_op(1'b1, 8'h45, 1'b0, "add45");
        run_op(1'b1, 8'h67, 1'b0, "add67");
        check_eq("add_two_done", done_cnt - d0, 2);
        check_eq("score_0112", m_score, 112);

        // Simultaneous add and decrement
        run_op(1'b1, 8'h08, 1'b1, "both");

        // External write during the last engine digit write is dropped
        d0 = done_cnt;
        bus.add_req = 1'b1;
        bus.add_pts = 8'h01;
        tick();
        bus.add_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("coll_busy", bus.busy, 1);
        bus.we = 1'b1;
        bus.write_address = ADDR_W'(9);
        bus.data_In = 8'h58;
        tick();
        bus.we = 1'b0;
        wait_quiet("coll");
        check_eq("coll_done", done_cnt - d0, 1);
        model_add(8'h01);
        model_cells();
        status_chk("coll");

        // Out-of-range write and read
        ext_wr(200, 8'h77);
        rd_chk(200);
        rd_chk(72);
        rd_chk(40);

        // Same-cycle read and write returns the old data
        bus.read_address = ADDR_W'(100);
        bus.we = 1'b1;
        bus.write_address = ADDR_W'(100);
        bus.data_In = 8'hA5;
        tick();
        bus.we = 1'b0;
        check_eq("rdw_old", bus.data_Out, m_mem[100]);
        m_mem[100] = 8'hA5;
        rd_chk(100);

        // Repeat add while pending overwrites the points
        d0 = done_cnt;
        bus.add_req = 1'b1;
        bus.add_pts = 8'h01;
        tick();
        bus.add_req = 1'b0;
        tick();
        tick();
        bus.add_req = 1'b1;
        bus.add_pts = 8'h11;
        tick();
        bus.add_pts = 8'h22;
        tick();
        bus.add_req = 1'b0;
        wait_quiet("pend");
        check_eq("pend_done", done_cnt - d0, 2);
        model_add(8'h01);
        model_add(8'h22);
        model_cells();
        status_chk("pend");

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: run_op(1'b1, rand_bcd(), 1'b0, "radd");
                1: run_op(1'b0, 8'h00, 1'b1, "rdec");
                2: run_op(1'b1, rand_bcd(), 1'b1, "rboth");
                default: begin
                    a = int'($urandom_range(0, 255));
                    d = 8'($urandom);
                    ext_wr(a, d);
                    rd_chk(a);
                end
            endcase
        end

        // Reset in the middle of a write-back keeps the text cells
        ext_wr(100, 8'h5A);
        bus.add_req = 1'b1;
        bus.add_pts = 8'h33;
        tick();
        bus.add_req = 1'b0;
        tick();
        tick();
        do_reset("rstmid");
        sweep();

        // Three decrements from reset
        run_op(1'b0, 8'h00, 1'b1, "dec1");
        check_eq("dec1_cell", m_mem[LA], 8'h31);
        run_op(1'b0, 8'h00, 1'b1, "dec2");
        check_eq("dec2_gover", bus.game_over, 1);
        run_op(1'b0, 8'h00, 1'b1, "dec3");
        check_eq("dec3_cell", m_mem[LA], 8'h30);

        // Saturation: 9990 + 25
        for (int i = 0; i < 100; i++) run_op(1'b1, 8'h99, 1'b0, "sat99");
        run_op(1'b1, 8'h90, 1'b0, "sat90");
        check_eq("score_9990", m_score, 9990);
        run_op(1'b1, 8'h25, 1'b0, "sat25");
        check_eq("score_9999", m_score, 9999);

        sweep();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hud_ram.md
HUD_RAM -- requirements
Module: hud_ram

Interface
REQ-001 Parameter DEPTH, default 160: number of character cells.
REQ-002 Parameter ADDR_W, default 8: address width; DEPTH SHALL be at most 2^ADDR_W.
REQ-003 Parameter SCORE_BASE, default 7: address of the most significant score digit.
REQ-004 Parameter SCORE_DIGITS, default 4: number of BCD score digits, 1..8.
REQ-005 Parameter LIVES_ADDR, default 32: address of the single lives digit.
REQ-006 Parameter LIVES_INIT, default 2: lives value after reset, 0..9.
REQ-007 Clk  in  1  single clock; all logic on posedge.
REQ-008 Reset_n  in  1  synchronous, active-low reset.
REQ-009 data_In  in  8  external write data (ASCII).
REQ-010 write_address  in  ADDR_W  external write address.
REQ-011 we  in  1  external write enable.
REQ-012 read_address  in  ADDR_W  display read address.
REQ-013 data_Out  out  8  registered read data.
REQ-014 add_req  in  1  one-cycle pulse: add add_pts to the score.
REQ-015 add_pts  in  8  two BCD digits (tens, units), sampled with add_req.
REQ-016 lives_dec  in  1  one-cycle pulse: lose one life.
REQ-017 busy  out  1  high while the engine is not in IDLE.
REQ-018 done  out  1  one-cycle pulse when a write-back completes.
REQ-019 game_over  out  1  high while lives == 0.

Function
REQ-020 Memory SHALL be DEPTH x 8 and power up with "Score:" at 0..5, ASCII '0' at SCORE_BASE..SCORE_BASE+SCORE_DIGITS-1, "Lives:" at 25..30, ASCII LIVES_INIT at LIVES_ADDR, and 0x00 in every other cell.
REQ-021 data_Out SHALL equal mem[read_address] one cycle after the address is presented; a same-cycle write to that address SHALL return the old data; read_address >= DEPTH SHALL return 0x00.
REQ-022 Any write to an address >= DEPTH SHALL be ignored.
REQ-023 The engine SHALL hold score as SCORE_DIGITS BCD digits and lives as a 4-bit value (0..9).
REQ-024 FSM states: IDLE, ADD, SCORE_WB, LIVES_WB.
REQ-025 The engine SHALL hold two pending flags, pend_add (with a latched add_pts) and pend_dec; a request pulse SHALL set its flag in any state. A repeat request while its flag is set SHALL overwrite add_pts but not queue a second add.
REQ-026 IDLE SHALL go to ADD if pend_add is set, otherwise to LIVES_WB if pend_dec is set; score is always serviced before lives.
REQ-027 ADD SHALL take 1 cycle: BCD add of latched add_pts into the score, saturating at all 9s; clear pend_add; go to SCORE_WB.
REQ-028 SCORE_WB SHALL take SCORE_DIGITS cycles, writing 0x30+digit most-significant first starting at SCORE_BASE; then go to LIVES_WB if pend_dec is set, otherwise to IDLE.
REQ-029 LIVES_WB SHALL take 1 cycle: lives = max(lives-1, 0); write 0x30+lives to LIVES_ADDR; clear pend_dec; go to IDLE.
REQ-030 Latency: add_req at cycle 0 -> ADD at cycle 1 -> digit writes at cycles 2..SCORE_DIGITS+1 -> done high in cycle SCORE_DIGITS+2.
REQ-031 done SHALL pulse for exactly one cycle on each transition into IDLE from SCORE_WB or LIVES_WB.
REQ-032 Engine writes SHALL take priority; an external we in a cycle where the engine writes SHALL be dropped. External writes SHALL otherwise be accepted in any state.
REQ-033 lives_dec at lives == 0 SHALL still rewrite '0' and pulse done; game_over SHALL stay high.

Reset
REQ-034 With Reset_n low at a clock edge: score = 0, lives = LIVES_INIT, pend_add = 0, pend_dec = 0, done = 0, data_Out = 0x00, game_over = (LIVES_INIT == 0).
REQ-035 Reset SHALL put the FSM in SCORE_WB with a forced lives write-back, so the RAM score and lives cells are restored after reset. busy SHALL be high during this write-back, and done SHALL pulse at its end.
REQ-036 Reset mid write-back SHALL abandon the operation and follow REQ-035. Other text cells SHALL NOT be cleared.

Verification
REQ-037 After reset completes, read addresses 7..10 and 32 -> 0x30,0x30,0x30,0x30,0x32; address 0 -> 0x53.
REQ-038 add_req with add_pts=0x45, then add_req with add_pts=0x67 after done -> cells 7..10 read 0x30,0x31,0x31,0x32 ("0112"); done pulses twice.
REQ-039 Score 9990, add_pts=0x25 -> score saturates; cells 7..10 read 0x39 x4.
REQ-040 add_req and lives_dec in the same cycle -> 4 score writes then 1 lives write; one done pulse after the lives write; cell 32 = 0x31.
REQ-041 Three lives_dec from reset -> cell 32 goes '1','0','0'; game_over rises after the second decrement.
REQ-042 External we to address 9 in the same cycle as an engine write -> external write dropped; we to address 200 -> no effect; read of address 200 -> 0x00.
